// File: rtl/adder_eval_pkg.sv
// Shared types and default widths for the approximate-adder error monitors.
package adder_eval_pkg;

  localparam int unsigned SUM_W = 17;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ACC_W = 48;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // S1 payload; d is sized for the default sum width.
  typedef struct packed {
    logic             valid;
    logic             ne;
    logic [SUM_W-1:0] d;
  } s1_t;

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned |a - b| via a W+1-bit two's-complement difference.
module abs_diff #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] diff;

  // The magnitude of a W+1-bit difference of two W-bit unsigned values fits in W bits.
  assign diff = {1'b0, a} - {1'b0, b};
  assign y    = diff[W] ? W'(~diff + 1'b1) : diff[W-1:0];

endmodule

// File: rtl/adder_error_monitor.sv
// Accumulates mismatch count, worst-case and summed absolute error over a fixed-length
// stream of (exact, approximate) sum pairs.
module adder_error_monitor #(
  parameter int unsigned W     = adder_eval_pkg::SUM_W,
  parameter int unsigned CNT_W = adder_eval_pkg::CNT_W,
  parameter int unsigned ACC_W = adder_eval_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     exact_sum,
  input  logic [W-1:0]     approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [W-1:0]     max_abs_err,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic             sat
);

  import adder_eval_pkg::SUM_W;
  import adder_eval_pkg::state_e;
  import adder_eval_pkg::s1_t;
  import adder_eval_pkg::StIdle;
  import adder_eval_pkg::StRun;
  import adder_eval_pkg::StDrain;
  import adder_eval_pkg::StDone;

  localparam int unsigned ExtW = ACC_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  s1_t              s1_q, s1_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [W-1:0]     max_q, max_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sat_q, sat_d;

  logic [W-1:0]     d_abs;
  logic [W-1:0]     s1_dw;
  logic [ExtW-1:0]  sum_ext;
  logic             accept;
  logic             clear;

  abs_diff #(
    .W(W)
  ) u_abs_diff (
    .a(exact_sum),
    .b(approx_sum),
    .y(d_abs)
  );

  // Ready depends only on state and counters, never on in_valid.
  assign in_ready = (state_q == StRun) && (accepted_q < target_q);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);

  assign err_count   = err_q;
  assign max_abs_err = max_q;
  assign sum_abs_err = sum_q;
  assign sat         = sat_q;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    accepted_d = accepted_q;
    clear      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          clear      = 1'b1;
          target_d   = num_samples;
          accepted_d = '0;
          state_d    = (num_samples == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          accepted_d = accepted_q + CNT_W'(1);
          if (accepted_d == target_q) state_d = StDrain;
        end
      end
      // The final sample is in S1 on the first DRAIN cycle; once S1 empties, S2 has it.
      StDrain: begin
        if (!s1_q.valid) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s1_d.valid = accept;
    s1_d.ne    = |d_abs;
    s1_d.d     = SUM_W'(d_abs);
  end

  always_comb begin
    err_d   = err_q;
    max_d   = max_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    s1_dw   = W'(s1_q.d);
    sum_ext = {1'b0, sum_q} + ExtW'(s1_dw);
    if (clear) begin
      err_d = '0;
      max_d = '0;
      sum_d = '0;
      sat_d = 1'b0;
    end else if (s1_q.valid) begin
      err_d = err_q + CNT_W'(s1_q.ne);
      if (s1_dw > max_q) max_d = s1_dw;
      if (sum_ext[ACC_W]) begin
        sum_d = '1;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      accepted_q <= '0;
      s1_q       <= '0;
      err_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      accepted_q <= accepted_d;
      s1_q       <= s1_d;
      err_q      <= err_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      sat_q      <= sat_d;
    end
  end

endmodule
